reg_writeback_arbiter: RTL and testbench
========================================

// Module: reg_writeback_arbiter
// PURPOSE
// - Write-side master of the register bank: collects results from two producers (ALU, MEM/load)
//   over valid/ready handshakes, buffers them, and drives the bank's single write port
//   (WE3/RA3/WD3), one write per cycle.
// - Decouples producer stalls from the one-write-per-cycle bank limit; round-robin fairness.
// PARAMETERS
// - WIDTH   32  data width, equals bank WIDTH
// - ADDR_W  4   register address width, equals bank address width
// - DEPTH   4   entries per source queue, power of 2, >=2
// PORTS
// - CLK      in   1                       clock, all state on posedge
// - RST_N    in   1                       asynchronous, active-low reset
// - FLUSH    in   1                       synchronous clear of queues and output register
// - A_VALID  in   1                       ALU result valid
// - A_READY  out  1                       ALU queue can accept
// - A_ADDR   in   ADDR_W                  ALU destination register
// - A_DATA   in   WIDTH                   ALU result
// - M_VALID  in   1                       MEM result valid
// - M_READY  out  1                       MEM queue can accept
// - M_ADDR   in   ADDR_W                  MEM destination register
// - M_DATA   in   WIDTH                   MEM result
// - WE3      out  1                       bank write enable, registered
// - RA3      out  ADDR_W                  bank write address, registered
// - WD3      out  WIDTH                   bank write data, registered
// - PENDING  out  $clog2(2*DEPTH)+1       total entries held in both queues
// BEHAVIOUR
// - Reset (RST_N=0, async): queues empty, WE3=0, RA3=0, WD3=0, PENDING=0, RR pointer=ALU;
//   A_READY=M_READY=1 from the first cycle after reset deassertion.
// - Accept: push on X_VALID&X_READY at posedge. X_READY = !full(X) & !FLUSH, from registered
//   count only; a full queue refuses a push even when it pops in the same cycle.
// - VALID/ADDR/DATA must hold until accepted; a dropped VALID without a handshake is legal (no push).
// - Arbitration each cycle: only A non-empty -> pop A; only M non-empty -> pop M; both -> pop the
//   source the RR pointer names, then point the pointer at the other source. Pointer unchanged on idle.
// - Output: popped head registered into WE3=1/RA3/WD3 at the same edge; WE3=0 on no pop.
// - Latency: accept at edge n -> WE3=1 during cycle n+1..n+2 window, i.e. earliest WE3 high after
//   edge n+1, bank written at edge n+2. No combinational input->WE3 path.
// - Throughput: 1 write/cycle sustained; with both sources saturated, strict alternation A,M,A,M.
// - Order: per-source FIFO order guaranteed. Cross-source ordering to the same register is NOT
//   guaranteed; issue logic must not have both sources target one register concurrently.
// - Simultaneous push+pop on one queue: count unchanged, both take effect.
// - Empty queue: never popped; WE3 stays 0 when both are empty.
// - Pointers wrap modulo DEPTH; count in 0..DEPTH (extra bit distinguishes full from empty).
// - FLUSH=1: at edge, both queues emptied, WE3<=0, RR pointer<=ALU; pushes in that cycle are
//   discarded (READY already low). Writes already presented on WE3 before the edge complete.
// - Reset mid-stream: all queued writes lost, WE3 drops immediately (async).
// - PENDING = count(A)+count(M), registered counts, updated every edge.
// STRUCTURE
// - Package wb_pkg: WB_WIDTH=32, WB_ADDR_W=4 defaults; typedef struct packed {addr,data} wb_req_t;
//   typedef enum logic {SRC_ALU, SRC_MEM} wb_src_t (RR pointer type).
// - Sub-module wb_fifo (DEPTH, wb_req_t payload; push/pop/full/empty/count), instantiated twice;
//   top holds the RR arbiter and output register.
// TESTING
// - Reset: RST_N low with A_VALID=1 -> WE3=0, PENDING=0, no push; RST_N high -> A_READY=1.
// - Single ALU write: A_ADDR=3, A_DATA=0xDEADBEEF at edge n -> WE3=1, RA3=3, WD3=0xDEADBEEF
//   for exactly one cycle after edge n+1.
// - Contention: both valid every cycle, A addrs 1,2,3 / M addrs 9,10,11 -> RA3 = 1,9,2,10,3,11.
// - Backpressure: DEPTH=4, M only, no pops possible -> 4 pushes accepted, M_READY=0, PENDING=4,
//   5th held; after drain, 5th written last, order intact.
// - Full+pop same cycle: full queue draining -> READY low that cycle, push accepted next cycle,
//   no entry lost or duplicated.
// - FLUSH with PENDING=5 -> next cycle PENDING=0, WE3=0, RR=ALU; subsequent push proceeds normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-bank write-back path: request payload and
// round-robin source identifier.
package wb_pkg;

   localparam int unsigned WB_WIDTH  = 32;
   localparam int unsigned WB_ADDR_W = 4;
   localparam int unsigned WB_DEPTH  = 4;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_WIDTH-1:0]  data;
   } wb_req_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of write-back requests; count carries one extra bit so
// full and empty are distinguishable.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  wb_req_t                  din,
   output wb_req_t                  head_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full_c  = (count == CNT_W'(DEPTH));
   assign empty_c = (count == '0);
   assign head_c  = mem[rd_ptr];
   assign do_push = push & ~full_c;
   assign do_pop  = pop & ~empty_c;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Write-side master of the register bank: queues ALU and MEM results and
// issues one registered bank write per cycle with round-robin fairness.
module reg_writeback_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned WIDTH  = WB_WIDTH,
   parameter int unsigned ADDR_W = WB_ADDR_W,
   parameter int unsigned DEPTH  = WB_DEPTH
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          FLUSH,
   input  logic                          A_VALID,
   output logic                          A_READY,
   input  logic [ADDR_W-1:0]             A_ADDR,
   input  logic [WIDTH-1:0]              A_DATA,
   input  logic                          M_VALID,
   output logic                          M_READY,
   input  logic [ADDR_W-1:0]             M_ADDR,
   input  logic [WIDTH-1:0]              M_DATA,
   output logic                          WE3,
   output logic [ADDR_W-1:0]             RA3,
   output logic [WIDTH-1:0]              WD3,
   output logic [$clog2(2*DEPTH):0]      PENDING
);

   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned PEND_W = $clog2(2*DEPTH) + 1;

   wb_src_t            rr_q;
   wb_src_t            rr_d;
   wb_req_t            a_din;
   wb_req_t            m_din;
   wb_req_t            a_head;
   wb_req_t            m_head;
   wb_req_t            win;
   logic               a_full;
   logic               m_full;
   logic               a_empty;
   logic               m_empty;
   logic               a_pop;
   logic               m_pop;
   logic [CNT_W-1:0]   a_count;
   logic [CNT_W-1:0]   m_count;

   // Readiness looks only at the registered count, never at a same-cycle pop.
   assign A_READY = ~a_full & ~FLUSH;
   assign M_READY = ~m_full & ~FLUSH;
   assign a_din   = '{addr: WB_ADDR_W'(A_ADDR), data: WB_WIDTH'(A_DATA)};
   assign m_din   = '{addr: WB_ADDR_W'(M_ADDR), data: WB_WIDTH'(M_DATA)};
   assign PENDING = PEND_W'(a_count) + PEND_W'(m_count);

   wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
      .clk     (CLK),
      .rst_n   (RST_N),
      .flush   (FLUSH),
      .push    (A_VALID & A_READY),
      .pop     (a_pop),
      .din     (a_din),
      .head_c  (a_head),
      .full_c  (a_full),
      .empty_c (a_empty),
      .count   (a_count)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_mem_q (
      .clk     (CLK),
      .rst_n   (RST_N),
      .flush   (FLUSH),
      .push    (M_VALID & M_READY),
      .pop     (m_pop),
      .din     (m_din),
      .head_c  (m_head),
      .full_c  (m_full),
      .empty_c (m_empty),
      .count   (m_count)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rr_q <= SRC_ALU;
      else        rr_q <= rr_d;
   end

   // Pointer only moves when both sources compete; flush parks it on ALU.
   always_comb begin
      a_pop = 1'b0;
      m_pop = 1'b0;
      rr_d  = rr_q;
      win   = a_head;
      if (FLUSH) begin
         rr_d = SRC_ALU;
      end else if (!a_empty && !m_empty) begin
         if (rr_q == SRC_ALU) begin
            a_pop = 1'b1;
            rr_d  = SRC_MEM;
         end else begin
            m_pop = 1'b1;
            rr_d  = SRC_ALU;
         end
      end else if (!a_empty) begin
         a_pop = 1'b1;
      end else if (!m_empty) begin
         m_pop = 1'b1;
      end
      if (m_pop) win = m_head;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         WE3 <= 1'b0;
         RA3 <= '0;
         WD3 <= '0;
      end else begin
         WE3 <= a_pop | m_pop;
         if (a_pop | m_pop) begin
            RA3 <= ADDR_W'(win.addr);
            WD3 <= WIDTH'(win.data);
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scoreboard bench for reg_writeback_arbiter: queue-level reference model,
// handshake-aware producers and an independent output monitor.
module tb_reg_writeback_arbiter;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic        CLK;
   logic        RST_N;
   logic        FLUSH;
   logic        A_VALID, A_READY, M_VALID, M_READY;
   logic [3:0]  A_ADDR, M_ADDR, RA3;
   logic [31:0] A_DATA, M_DATA, WD3;
   logic        WE3;
   logic [3:0]  PENDING;

   reg_writeback_arbiter #(.WIDTH(32), .ADDR_W(4), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
      .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_ADDR(M_ADDR), .M_DATA(M_DATA),
      .WE3(WE3), .RA3(RA3), .WD3(WD3), .PENDING(PENDING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // producer backlogs, reference queues, expected-write scoreboard
   wb_req_t    a_src[$], m_src[$];
   wb_req_t    qa[$], qm[$], sb[$];
   logic [3:0] obs[$];
   int         exp_pending = 0;
   bit         acc_a = 0, acc_m = 0;
   bit         rr_mem = 0;
   bit         started = 0;
   bit         drop_en = 0;
   int         pct = 100;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: two FIFOs, strict round-robin when both hold entries.
   initial forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
         qa.delete(); qm.delete(); sb.delete();
         rr_mem = 0; acc_a = 0; acc_m = 0; exp_pending = 0;
      end else if (FLUSH) begin
         qa.delete(); qm.delete();
         rr_mem = 0; acc_a = 0; acc_m = 0; exp_pending = 0;
      end else begin
         bit take_a, take_m;
         acc_a  = A_VALID && (qa.size() < DEPTH);
         acc_m  = M_VALID && (qm.size() < DEPTH);
         take_a = (qa.size() > 0) && ((qm.size() == 0) || !rr_mem);
         take_m = (qm.size() > 0) && !take_a;
         if (qa.size() > 0 && qm.size() > 0) rr_mem = !rr_mem;
         if (take_a) sb.push_back(qa.pop_front());
         if (take_m) sb.push_back(qm.pop_front());
         if (acc_a) qa.push_back('{addr: A_ADDR, data: A_DATA});
         if (acc_m) qm.push_back('{addr: M_ADDR, data: M_DATA});
         exp_pending = qa.size() + qm.size();
      end
   end

   // Monitor: every cycle compare bank port, occupancy and readiness.
   initial forever begin
      @(negedge CLK);
      if (RST_N && started) begin
         wb_req_t e;
         chk("we3", 64'(WE3), 64'(sb.size() > 0));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (WE3) begin
               chk("ra3", 64'(RA3), 64'(e.addr));
               chk("wd3", 64'(WD3), 64'(e.data));
               obs.push_back(RA3);
            end
         end
         chk("pending", 64'(PENDING), 64'(exp_pending));
         chk("a_ready", 64'(A_READY), 64'((qa.size() < DEPTH) && !FLUSH));
         chk("m_ready", 64'(M_READY), 64'((qm.size() < DEPTH) && !FLUSH));
      end
   end

   // Producers hold VALID/ADDR/DATA until accepted; may drop VALID when allowed.
   task automatic drive_loop();
      forever begin
         @(posedge CLK);
         #1;
         if (A_VALID && acc_a) begin a_src.delete(0); A_VALID = 0; end
         if (M_VALID && acc_m) begin m_src.delete(0); M_VALID = 0; end
         if (!A_VALID) begin
            if (a_src.size() > 0 && $urandom_range(99) < pct) begin
               A_VALID = 1; A_ADDR = a_src[0].addr; A_DATA = a_src[0].data;
            end
         end else if (drop_en && $urandom_range(7) == 0) A_VALID = 0;
         if (!M_VALID) begin
            if (m_src.size() > 0 && $urandom_range(99) < pct) begin
               M_VALID = 1; M_ADDR = m_src[0].addr; M_DATA = m_src[0].data;
            end
         end else if (drop_en && $urandom_range(7) == 0) M_VALID = 0;
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge CLK);
         #3;
         if (a_src.size() == 0 && m_src.size() == 0 && !A_VALID && !M_VALID &&
             qa.size() == 0 && qm.size() == 0 && sb.size() == 0) begin
            @(negedge CLK);
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: traffic still outstanding after %0d cycles", budget);
   endtask

   initial begin
      int exp_ord[6] = '{1, 9, 2, 10, 3, 11};
      bit hit;
      RST_N = 0; FLUSH = 0;
      A_VALID = 1; A_ADDR = 4'd5; A_DATA = 32'h5555_5555;
      M_VALID = 0; M_ADDR = '0;   M_DATA = '0;
      repeat (3) @(negedge CLK);
      chk("reset_we3", 64'(WE3), 64'd0);
      chk("reset_pending", 64'(PENDING), 64'd0);
      chk("reset_ra3", 64'(RA3), 64'd0);
      A_VALID = 0;
      RST_N   = 1;
      @(negedge CLK);
      chk("post_reset_a_ready", 64'(A_READY), 64'd1);
      chk("post_reset_pending", 64'(PENDING), 64'd0);
      started = 1;
      fork drive_loop(); join_none

      // single ALU write
      obs.delete();
      a_src.push_back('{addr: 4'd3, data: 32'hDEAD_BEEF});
      wait_idle(50);
      chk("single_count", 64'(obs.size()), 64'd1);
      if (obs.size() > 0) chk("single_addr", 64'(obs[0]), 64'd3);

      // contention: expect strict alternation starting with ALU
      obs.delete();
      for (int i = 0; i < 3; i++) begin
         a_src.push_back('{addr: 4'(i + 1), data: 32'hA000_0000 + 32'(i)});
         m_src.push_back('{addr: 4'(i + 9), data: 32'hB000_0000 + 32'(i)});
      end
      wait_idle(50);
      chk("contention_count", 64'(obs.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < obs.size()) chk("contention_order", 64'(obs[i]), 64'(exp_ord[i]));

      // saturate both until five are pending, then flush
      for (int i = 0; i < 10; i++) begin
         a_src.push_back('{addr: 4'($urandom_range(15)), data: $urandom()});
         m_src.push_back('{addr: 4'($urandom_range(15)), data: $urandom()});
      end
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(posedge CLK);
         #2;
         if (exp_pending == 5) begin FLUSH = 1; hit = 1; end
      end
      chk("flush_reached_5", 64'(hit), 64'd1);
      @(posedge CLK);
      #1 FLUSH = 0;
      @(negedge CLK);
      chk("flush_pending", 64'(PENDING), 64'd0);
      chk("flush_we3", 64'(WE3), 64'd0);
      wait_idle(200);

      // randomized traffic at several offered loads, with VALID drops
      drop_en = 1;
      foreach (exp_ord[k]) begin
         if (k < 3) begin
            pct = (k == 0) ? 25 : (k == 1) ? 60 : 100;
            for (int i = 0; i < 60; i++) begin
               a_src.push_back('{addr: 4'($urandom_range(15)), data: $urandom()});
               m_src.push_back('{addr: 4'($urandom_range(15)), data: $urandom()});
            end
            wait_idle(3000);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
